// File: rtl/ip_tx_mac_resolver.sv
`default_nettype none
// ============================================================================
// Module   : ip_tx_mac_resolver
// Purpose  : Resolves the Ethernet destination MAC for outgoing IP packets.
//            Looks up the destination IP in this order:
//              1. limited broadcast 255.255.255.255
//              2. multicast mapping (when IP_TX_MULTICAST_MAP_EN is defined)
//              3. a small fully-associative IP->MAC cache
//              4. ARP query, with a bounded wait
//            It then forwards header + MAC + payload downstream. Unresolvable
//            packets are dropped: their payload is consumed and discarded.
// Params   : CACHE_DEPTH - cache entries (power of two, 1..16)
//            ARP_TIMEOUT - clk cycles to wait for an ARP response (>= 1)
// Macro    : IP_TX_MULTICAST_MAP_EN - map 224.0.0.0/4 to 01:00:5e:xx:xx:xx
// Ports    : clk, rst_n (async, active-low)
//            s_ip_hdr_*            header in (dest IP held while valid)
//            s_ip_payload_axis_*   payload in
//            m_hdr_*, m_eth_dest_mac   resolved header out
//            m_ip_payload_axis_*   payload out (gated until header accepted)
//            arp_request_* / arp_response_*   ARP requester interface
//            cache_flush           clear all cache entries
//            stat_*                one-cycle event pulses
// Revision : 1.0 - initial release
// ============================================================================
module ip_tx_mac_resolver #(
    parameter int CACHE_DEPTH = 4,
    parameter int ARP_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_ip_hdr_valid,
    output logic        s_ip_hdr_ready,
    input  logic [31:0] s_ip_dest_ip,
    input  logic [7:0]  s_ip_payload_axis_tdata,
    input  logic        s_ip_payload_axis_tvalid,
    output logic        s_ip_payload_axis_tready,
    input  logic        s_ip_payload_axis_tlast,
    output logic        m_hdr_valid,
    input  logic        m_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [7:0]  m_ip_payload_axis_tdata,
    output logic        m_ip_payload_axis_tvalid,
    input  logic        m_ip_payload_axis_tready,
    output logic        m_ip_payload_axis_tlast,
    output logic        arp_request_valid,
    input  logic        arp_request_ready,
    output logic [31:0] arp_request_ip,
    input  logic        arp_response_valid,
    output logic        arp_response_ready,
    input  logic        arp_response_error,
    input  logic [47:0] arp_response_mac,
    input  logic        cache_flush,
    output logic        stat_cache_hit,
    output logic        stat_drop,
    output logic        stat_arp_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARP_REQ  = 3'd1,
        ST_ARP_WAIT = 3'd2,
        ST_FORWARD  = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    localparam int c_PTR_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(ARP_TIMEOUT + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(CACHE_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ARP_TIMEOUT - 1);

    state_t               r_state, w_state_nxt;
    logic                 r_hdr_ready, w_hdr_ready_nxt;
    logic                 r_m_hdr_valid, w_m_hdr_valid_nxt;
    logic [47:0]          r_mac, w_mac_nxt;
    logic                 r_arp_req_valid, w_arp_req_valid_nxt;
    logic [31:0]          r_dest_ip, w_dest_ip_nxt;
    logic                 r_arp_resp_ready, w_arp_resp_ready_nxt;
    logic                 r_stat_hit, w_stat_hit_nxt;
    logic                 r_stat_drop, w_stat_drop_nxt;
    logic                 r_stat_to, w_stat_to_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 w_insert;

    logic [c_PTR_W-1:0]   r_ptr;
    logic [CACHE_DEPTH-1:0] r_cache_vld;
    logic [31:0]          r_cache_ip  [CACHE_DEPTH];
    logic [47:0]          r_cache_mac [CACHE_DEPTH];
    logic [CACHE_DEPTH-1:0] w_hit_vec;
    logic                 w_hit;
    logic [47:0]          w_hit_mac;
    logic                 w_bcast;
    logic                 w_mcast;
    logic [47:0]          w_mcast_mac;
    logic                 w_fwd;
    logic                 w_last_hs;

    // ---------------- lookup ----------------
    generate
        for (genvar gi = 0; gi < CACHE_DEPTH; gi++) begin : g_lookup
            assign w_hit_vec[gi] = r_cache_vld[gi] && (r_cache_ip[gi] == s_ip_dest_ip);
        end
    endgenerate

    // Entries are only inserted after a miss, so at most one can match.
    always_comb begin
        w_hit_mac = '0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            if (w_hit_vec[i]) begin
                w_hit_mac = r_cache_mac[i];
            end
        end
    end

    assign w_hit       = |w_hit_vec;
    assign w_bcast     = (s_ip_dest_ip == 32'hFFFF_FFFF);
    assign w_mcast_mac = {24'h01005E, 1'b0, s_ip_dest_ip[22:0]};
`ifdef IP_TX_MULTICAST_MAP_EN
    assign w_mcast     = (s_ip_dest_ip[31:28] == 4'b1110);
`else
    assign w_mcast     = 1'b0;
`endif

    // ---------------- payload gating ----------------
    // Payload may only flow once the downstream has taken the header.
    assign w_fwd = (r_state == ST_FORWARD) && !r_m_hdr_valid;
    assign m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata;
    assign m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast;
    assign m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid && w_fwd;
    assign s_ip_payload_axis_tready = w_fwd ? m_ip_payload_axis_tready : (r_state == ST_DROP);
    assign w_last_hs = s_ip_payload_axis_tvalid && s_ip_payload_axis_tready
                       && s_ip_payload_axis_tlast;

    // ---------------- next-state / next-output ----------------
    always_comb begin
        w_state_nxt          = r_state;
        w_hdr_ready_nxt      = 1'b0;
        w_m_hdr_valid_nxt    = r_m_hdr_valid && !m_hdr_ready;
        w_mac_nxt            = r_mac;
        w_arp_req_valid_nxt  = r_arp_req_valid;
        w_dest_ip_nxt        = r_dest_ip;
        w_arp_resp_ready_nxt = r_arp_resp_ready;
        w_stat_hit_nxt       = 1'b0;
        w_stat_drop_nxt      = 1'b0;
        w_stat_to_nxt        = 1'b0;
        w_cnt_nxt            = r_cnt;
        w_insert             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_ip_hdr_valid) begin
                    w_dest_ip_nxt = s_ip_dest_ip;
                    if (w_bcast || w_mcast || w_hit) begin
                        w_state_nxt       = ST_FORWARD;
                        w_hdr_ready_nxt   = 1'b1;
                        w_m_hdr_valid_nxt = 1'b1;
                        if (w_bcast) begin
                            w_mac_nxt = 48'hFFFF_FFFF_FFFF;
                        end else if (w_mcast) begin
                            w_mac_nxt = w_mcast_mac;
                        end else begin
                            w_mac_nxt      = w_hit_mac;
                            w_stat_hit_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt          = ST_ARP_REQ;
                        w_arp_req_valid_nxt  = 1'b1;
                        w_arp_resp_ready_nxt = 1'b1;
                    end
                end
            end
            ST_ARP_REQ: begin
                if (arp_request_ready) begin
                    w_state_nxt         = ST_ARP_WAIT;
                    w_arp_req_valid_nxt = 1'b0;
                    w_cnt_nxt           = '0;
                end
            end
            ST_ARP_WAIT: begin
                // A response in the final timeout cycle takes precedence.
                if (arp_response_valid) begin
                    w_arp_resp_ready_nxt = 1'b0;
                    w_hdr_ready_nxt      = 1'b1;
                    if (arp_response_error) begin
                        w_state_nxt     = ST_DROP;
                        w_stat_drop_nxt = 1'b1;
                    end else begin
                        w_state_nxt       = ST_FORWARD;
                        w_m_hdr_valid_nxt = 1'b1;
                        w_mac_nxt         = arp_response_mac;
                        w_insert          = 1'b1;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt          = ST_DROP;
                    w_arp_resp_ready_nxt = 1'b0;
                    w_hdr_ready_nxt      = 1'b1;
                    w_stat_drop_nxt      = 1'b1;
                    w_stat_to_nxt        = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_FORWARD, ST_DROP: begin
                if (w_last_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_hdr_ready      <= 1'b0;
            r_m_hdr_valid    <= 1'b0;
            r_mac            <= '0;
            r_arp_req_valid  <= 1'b0;
            r_dest_ip        <= '0;
            r_arp_resp_ready <= 1'b0;
            r_stat_hit       <= 1'b0;
            r_stat_drop      <= 1'b0;
            r_stat_to        <= 1'b0;
            r_cnt            <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_hdr_ready      <= w_hdr_ready_nxt;
            r_m_hdr_valid    <= w_m_hdr_valid_nxt;
            r_mac            <= w_mac_nxt;
            r_arp_req_valid  <= w_arp_req_valid_nxt;
            r_dest_ip        <= w_dest_ip_nxt;
            r_arp_resp_ready <= w_arp_resp_ready_nxt;
            r_stat_hit       <= w_stat_hit_nxt;
            r_stat_drop      <= w_stat_drop_nxt;
            r_stat_to        <= w_stat_to_nxt;
            r_cnt            <= w_cnt_nxt;
        end
    end

    // ---------------- cache bookkeeping ----------------
    // Flush wins over a same-cycle insert; the packet itself is still
    // forwarded with the freshly resolved MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_vld <= '0;
            r_ptr       <= '0;
        end else if (cache_flush) begin
            r_cache_vld <= '0;
            r_ptr       <= '0;
        end else if (w_insert) begin
            r_cache_vld[r_ptr] <= 1'b1;
            r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    // Data storage needs no reset: valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (w_insert && !cache_flush) begin
            r_cache_ip[r_ptr]  <= r_dest_ip;
            r_cache_mac[r_ptr] <= arp_response_mac;
        end
    end

    assign s_ip_hdr_ready     = r_hdr_ready;
    assign m_hdr_valid        = r_m_hdr_valid;
    assign m_eth_dest_mac     = r_mac;
    assign arp_request_valid  = r_arp_req_valid;
    assign arp_request_ip     = r_dest_ip;
    assign arp_response_ready = r_arp_resp_ready;
    assign stat_cache_hit     = r_stat_hit;
    assign stat_drop          = r_stat_drop;
    assign stat_arp_timeout   = r_stat_to;

endmodule
`default_nettype wire
